// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
//   Load/store controller between the execute stage and a word-organised data
//   RAM with a one-cycle registered read. RV32I byte/halfword/word loads are
//   extracted and extended from the read word. Sub-word stores are done as
//   read-modify-write because the RAM only writes whole words.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/SH (addr[0]) and W/SW (addr[1:0]) give resp_err
//   undefined : low address bits are ignored and the access is aligned down
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake, ready only in IDLE
//   req_we, req_funct3    1 = store; RV32I funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   req_addr, req_wdata   byte address, store data
//   resp_valid            one-cycle completion pulse, no backpressure
//   resp_rdata, resp_err  extended load data (0 for stores/errors), error flag
//   mem_wr_sig            RAM write enable, one cycle per store
//   mem_wr_data, mem_addr RAM write word, word-aligned RAM address
//   mem_rd_data           RAM read word, valid the cycle after mem_addr
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_valid while req_ready is low is ignored and
// never queued. resp_valid is a single-cycle pulse the core must consume.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_sig,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // FSM state register; named plainly so checkers can bind to it directly.
  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;   // only the low half is ever merged into a word

  logic        req_err;
  logic [31:0] ld_result;
  logic [31:0] merged;

  // Request legality, evaluated on the live request in IDLE.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'd3 || req_funct3 > 3'd5) req_err = 1'b1;
    end
`ifdef MISALIGN_TRAP_EN
    // funct3[1:0]: 01 = halfword (H/HU/SH), 10 = word (W/SW)
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  // Load extraction from the registered read word.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rd_data[7:0];
      2'd1:    lane_b = mem_rd_data[15:8];
      2'd2:    lane_b = mem_rd_data[23:16];
      default: lane_b = mem_rd_data[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (f3_q)
      3'd0:    ld_result = {{24{lane_b[7]}}, lane_b};
      3'd4:    ld_result = {24'h0, lane_b};
      3'd1:    ld_result = {{16{lane_h[15]}}, lane_h};
      3'd5:    ld_result = {16'h0, lane_h};
      default: ld_result = mem_rd_data;
    endcase
  end

  // Sub-word store merge: replace the addressed lane, keep the other bytes.
  always_comb begin
    merged = mem_rd_data;
    if (f3_q == 3'd0) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 16'h0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_wr_data <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= S_RESP;
            end else if (req_we && req_funct3 == 3'd2) begin
              mem_wr_data <= req_wdata;
              state       <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ:  state <= S_DATA;
        S_DATA: begin
          if (we_q) begin
            mem_wr_data <= merged;
            state       <= S_WRITE;
          end else begin
            resp_rdata <= ld_result;
            state      <= S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so the async reset drops the write enable at once.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_wr_sig = (state == S_WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a small registered-read RAM model, directed
// requests with hand-computed expected data, latency and write-pulse counts.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_sig;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;

  int total = 0;
  int bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_sig  (mem_wr_sig),
    .mem_wr_data (mem_wr_data),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data)
  );

  // RAM model: decodes addr[11:2], registered read, old data on collision.
  logic [31:0] ram [0:1023];
  always_ff @(posedge clk) begin
    if (mem_wr_sig) ram[mem_addr[11:2]] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // driver: issue one request and follow it to its response
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int wr_cnt,
                         output logic [31:0] addr_c1);
    lat = 0; wr_cnt = 0; rdata = 32'h0; err = 1'b0; addr_c1 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) addr_c1 = mem_addr;
      if (mem_wr_sig) wr_cnt++;
      if (resp_valid) begin
        lat = cyc; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_wr);
    logic [31:0] rd, a1;
    logic        e;
    int          l, w;
    run_req(we, f3, addr, wdata, rd, e, l, w, a1);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_wr"}, w, exp_wr);
    if (!exp_err) check({tag, "_addr"}, a1, {addr[31:2], 2'b00});
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_ready",  {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata",  resp_rdata, 32'h0);
    check("rst_err",    {31'd0, resp_err}, 32'd0);
    check("rst_wr",     {31'd0, mem_wr_sig}, 32'd0);
    check("rst_wdata",  mem_wr_data, 32'h0);
    check("rst_addr",   mem_addr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // word store then word load
    txn("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    txn("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

    // sub-word loads from 0x80FF7F01
    txn("sw10b", 1'b1, 3'd2, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2, 1);
    txn("lb13",  1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
    txn("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 0);
    txn("lh12",  1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);
    txn("lhu10", 1'b0, 3'd5, 32'h10, 32'h0, 32'h00007F01, 1'b0, 3, 0);
    txn("lb11",  1'b0, 3'd0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 3, 0);

    // misaligned halfword load
`ifdef MISALIGN_TRAP_EN
    txn("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    txn("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 32'h00007F01, 1'b0, 3, 0);
`endif

    // read-modify-write sub-word stores
    txn("sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1);
    txn("sb21", 1'b1, 3'd0, 32'h21, 32'hCDEF00AB, 32'h0, 1'b0, 4, 1);
    txn("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 32'h1122AB44, 1'b0, 3, 0);
    txn("sh22", 1'b1, 3'd1, 32'h22, 32'h9999BEEF, 32'h0, 1'b0, 4, 1);
    txn("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0, 3, 0);

    // illegal funct3
    txn("sf4", 1'b1, 3'd4, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    txn("lf3", 1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0);
    txn("lw20c", 1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0, 3, 0);

    // reset in the middle of a sub-word store
    txn("sw30", 1'b1, 3'd2, 32'h30, 32'h55667788, 32'h0, 1'b0, 2, 1);
    begin
      int wr_seen;
      wr_seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1;
      req_addr = 32'h30; req_wdata = 32'h00001234;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);               // c1
      if (mem_wr_sig) wr_seen++;
      @(negedge clk);               // c2
      if (mem_wr_sig) wr_seen++;
      reset_n = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_wr",    {31'd0, mem_wr_sig}, 32'd0);
      check("mid_rst_rvalid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (mem_wr_sig) wr_seen++;
      end
      check("mid_rst_wr_cnt", wr_seen, 0);
    end
    txn("lw30", 1'b0, 3'd2, 32'h30, 32'h0, 32'h55667788, 1'b0, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
